// File: rtl/aes_axil_cmd_master.sv
// AXI4-Lite initiator that runs one AES job on the accelerator's register slave:
// program key/IV/data/mode, start, poll STATUS, read DOUT, then clear start.
module aes_axil_cmd_master #(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter int unsigned POLL_LIMIT = 1024,
    parameter int unsigned DONE_BIT   = 0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [127:0] cmd_key,
    input  logic [127:0] cmd_iv,
    input  logic [127:0] cmd_data,
    input  logic [2:0]   cmd_mode,
    input  logic         cmd_enc_dec,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [127:0] res_data,
    output logic         res_err,
    output logic [31:0]  m_axi_awaddr,
    output logic         m_axi_awvalid,
    input  logic         m_axi_awready,
    output logic [31:0]  m_axi_wdata,
    output logic [3:0]   m_axi_wstrb,
    output logic         m_axi_wvalid,
    input  logic         m_axi_wready,
    input  logic [1:0]   m_axi_bresp,
    input  logic         m_axi_bvalid,
    output logic         m_axi_bready,
    output logic [31:0]  m_axi_araddr,
    output logic         m_axi_arvalid,
    input  logic         m_axi_arready,
    input  logic [31:0]  m_axi_rdata,
    input  logic [1:0]   m_axi_rresp,
    input  logic         m_axi_rvalid,
    output logic         m_axi_rready
);

    typedef enum logic [2:0] {
        StIdle, StWrReq, StWrResp, StRdReq, StRdResp, StStep, StResult
    } state_e;

    // Steps 0..11 are KEY/IV/DIN writes, 15..18 the DOUT reads.
    localparam logic [4:0]  StepMode  = 5'd12;
    localparam logic [4:0]  StepStart = 5'd13;
    localparam logic [4:0]  StepPoll  = 5'd14;
    localparam logic [4:0]  StepDout0 = 5'd15;
    localparam logic [4:0]  StepStop  = 5'd19;
    localparam logic [15:0] PollMax   = 16'(POLL_LIMIT);
    localparam logic [4:0]  DoneIdx   = 5'(DONE_BIT);

    state_e        state_q, state_d;
    logic [4:0]    step_q, step_d, nxt;
    logic [15:0]   poll_q, poll_d;
    logic          done_q, done_d;
    logic [127:0]  key_q, key_d, iv_q, iv_d, din_q, din_d;
    logic [2:0]    mode_q, mode_d;
    logic          enc_dec_q, enc_dec_d;
    logic [31:0]   awaddr_q, awaddr_d, wdata_q, wdata_d, araddr_q, araddr_d;
    logic          awvalid_q, awvalid_d, wvalid_q, wvalid_d, arvalid_q, arvalid_d;
    logic [127:0]  res_data_q, res_data_d;
    logic          res_err_q, res_err_d;

    function automatic logic [31:0] word_of(input logic [127:0] f, input logic [1:0] w);
        logic [31:0] r;
        unique case (w)
            2'd0: r = f[127:96];
            2'd1: r = f[95:64];
            2'd2: r = f[63:32];
            default: r = f[31:0];
        endcase
        return r;
    endfunction

    function automatic logic [127:0] put_word(input logic [127:0] f, input logic [1:0] w,
                                               input logic [31:0] v);
        logic [127:0] r;
        r = f;
        unique case (w)
            2'd0: r[127:96] = v;
            2'd1: r[95:64]  = v;
            2'd2: r[63:32]  = v;
            default: r[31:0] = v;
        endcase
        return r;
    endfunction

    // DOUT word index of steps 15..18 is step[1:0]+1 (wraps 3 -> 0).
    function automatic logic [31:0] step_addr(input logic [4:0] s);
        logic [31:0] off;
        if (s < StepMode)                       off = 32'h10 + {25'd0, s, 2'b00};
        else if (s == StepMode)                 off = 32'h08;
        else if (s == StepPoll)                 off = 32'h0C;
        else if (s >= StepDout0 && s < StepStop) off = 32'h40 + {28'd0, s[1:0] + 2'd1, 2'b00};
        else                                    off = 32'h00;
        return BASE_ADDR + off;
    endfunction

    function automatic logic step_is_read(input logic [4:0] s);
        return (s >= StepPoll) && (s < StepStop);
    endfunction

    function automatic logic [31:0] step_wdata(input logic [4:0] s, input logic [127:0] key,
                                               input logic [127:0] iv, input logic [127:0] din,
                                               input logic [2:0] mode, input logic enc_dec);
        logic [31:0] w;
        if (s < 5'd4)            w = word_of(key, s[1:0]);
        else if (s < 5'd8)       w = word_of(iv, s[1:0]);
        else if (s < StepMode)   w = word_of(din, s[1:0]);
        else if (s == StepMode)  w = {28'd0, enc_dec, mode};
        else if (s == StepStart) w = 32'd1;
        else                     w = 32'd0;
        return w;
    endfunction

    always_comb begin
        state_d    = state_q;
        step_d     = step_q;
        nxt        = step_q + 5'd1;
        poll_d     = poll_q;
        done_d     = done_q;
        key_d      = key_q;
        iv_d       = iv_q;
        din_d      = din_q;
        mode_d     = mode_q;
        enc_dec_d  = enc_dec_q;
        awaddr_d   = awaddr_q;
        wdata_d    = wdata_q;
        araddr_d   = araddr_q;
        awvalid_d  = awvalid_q;
        wvalid_d   = wvalid_q;
        arvalid_d  = arvalid_q;
        res_data_d = res_data_q;
        res_err_d  = res_err_q;

        unique case (state_q)
            StIdle: begin
                if (cmd_valid) begin
                    key_d      = cmd_key;
                    iv_d       = cmd_iv;
                    din_d      = cmd_data;
                    mode_d     = cmd_mode;
                    enc_dec_d  = cmd_enc_dec;
                    step_d     = 5'd0;
                    poll_d     = 16'd0;
                    done_d     = 1'b0;
                    res_err_d  = 1'b0;
                    res_data_d = '0;
                    awaddr_d   = step_addr(5'd0);
                    wdata_d    = cmd_key[127:96];
                    awvalid_d  = 1'b1;
                    wvalid_d   = 1'b1;
                    state_d    = StWrReq;
                end
            end
            StWrReq: begin
                awvalid_d = awvalid_q & ~m_axi_awready;
                wvalid_d  = wvalid_q & ~m_axi_wready;
                if (!awvalid_d && !wvalid_d) state_d = StWrResp;
            end
            StWrResp: begin
                if (m_axi_bvalid) begin
                    if (m_axi_bresp != 2'b00) begin
                        res_err_d = 1'b1;
                        state_d   = StResult;
                    end else begin
                        state_d = StStep;
                    end
                end
            end
            StRdReq: begin
                if (m_axi_arready) begin
                    arvalid_d = 1'b0;
                    state_d   = StRdResp;
                end
            end
            StRdResp: begin
                if (m_axi_rvalid) begin
                    if (m_axi_rresp != 2'b00) begin
                        res_err_d = 1'b1;
                        state_d   = StResult;
                    end else begin
                        if (step_q == StepPoll) begin
                            poll_d = poll_q + 16'd1;
                            done_d = m_axi_rdata[DoneIdx];
                        end else begin
                            res_data_d = put_word(res_data_q, step_q[1:0] + 2'd1, m_axi_rdata);
                        end
                        state_d = StStep;
                    end
                end
            end
            StStep: begin
                if (step_q == StepPoll) begin
                    if (done_q) begin
                        nxt = StepDout0;
                    end else if (poll_q >= PollMax) begin
                        // Timed out: skip DOUT but still clear start.
                        nxt       = StepStop;
                        res_err_d = 1'b1;
                    end else begin
                        nxt = StepPoll;
                    end
                end
                if (step_q == StepStop) begin
                    state_d = StResult;
                end else begin
                    step_d = nxt;
                    if (step_is_read(nxt)) begin
                        araddr_d  = step_addr(nxt);
                        arvalid_d = 1'b1;
                        state_d   = StRdReq;
                    end else begin
                        awaddr_d  = step_addr(nxt);
                        wdata_d   = step_wdata(nxt, key_q, iv_q, din_q, mode_q, enc_dec_q);
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = StWrReq;
                    end
                end
            end
            StResult: begin
                if (res_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            step_q     <= '0;
            poll_q     <= '0;
            done_q     <= 1'b0;
            key_q      <= '0;
            iv_q       <= '0;
            din_q      <= '0;
            mode_q     <= '0;
            enc_dec_q  <= 1'b0;
            awaddr_q   <= '0;
            wdata_q    <= '0;
            araddr_q   <= '0;
            awvalid_q  <= 1'b0;
            wvalid_q   <= 1'b0;
            arvalid_q  <= 1'b0;
            res_data_q <= '0;
            res_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            step_q     <= step_d;
            poll_q     <= poll_d;
            done_q     <= done_d;
            key_q      <= key_d;
            iv_q       <= iv_d;
            din_q      <= din_d;
            mode_q     <= mode_d;
            enc_dec_q  <= enc_dec_d;
            awaddr_q   <= awaddr_d;
            wdata_q    <= wdata_d;
            araddr_q   <= araddr_d;
            awvalid_q  <= awvalid_d;
            wvalid_q   <= wvalid_d;
            arvalid_q  <= arvalid_d;
            res_data_q <= res_data_d;
            res_err_q  <= res_err_d;
        end
    end

    assign cmd_ready     = (state_q == StIdle);
    assign res_valid     = (state_q == StResult);
    assign res_data      = res_data_q;
    assign res_err       = res_err_q;
    assign m_axi_awaddr  = awaddr_q;
    assign m_axi_awvalid = awvalid_q;
    assign m_axi_wdata   = wdata_q;
    assign m_axi_wstrb   = 4'hF;
    assign m_axi_wvalid  = wvalid_q;
    assign m_axi_bready  = (state_q == StWrResp);
    assign m_axi_araddr  = araddr_q;
    assign m_axi_arvalid = arvalid_q;
    assign m_axi_rready  = (state_q == StRdResp);

endmodule

// File: tb/tb_aes_axil_cmd_master.sv
// Directed bench for aes_axil_cmd_master against a small AXI4-Lite register slave model.
module tb_aes_axil_cmd_master;

    logic         clk = 1'b0;
    logic         reset;
    logic         cmd_valid, cmd_ready;
    logic [127:0] cmd_key, cmd_iv, cmd_data;
    logic [2:0]   cmd_mode;
    logic         cmd_enc_dec;
    logic         res_valid, res_ready, res_err;
    logic [127:0] res_data;
    logic [31:0]  awaddr, wdata, araddr, rdata;
    logic         awvalid, awready, wvalid, wready, bvalid, bready;
    logic         arvalid, arready, rvalid, rready;
    logic [3:0]   wstrb;
    logic [1:0]   bresp, rresp;

    always #5 clk = ~clk;

    aes_axil_cmd_master #(
        .BASE_ADDR (32'h0000_0000),
        .POLL_LIMIT(8),
        .DONE_BIT  (0)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_key      (cmd_key),
        .cmd_iv       (cmd_iv),
        .cmd_data     (cmd_data),
        .cmd_mode     (cmd_mode),
        .cmd_enc_dec  (cmd_enc_dec),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_data     (res_data),
        .res_err      (res_err),
        .m_axi_awaddr (awaddr),
        .m_axi_awvalid(awvalid),
        .m_axi_awready(awready),
        .m_axi_wdata  (wdata),
        .m_axi_wstrb  (wstrb),
        .m_axi_wvalid (wvalid),
        .m_axi_wready (wready),
        .m_axi_bresp  (bresp),
        .m_axi_bvalid (bvalid),
        .m_axi_bready (bready),
        .m_axi_araddr (araddr),
        .m_axi_arvalid(arvalid),
        .m_axi_arready(arready),
        .m_axi_rdata  (rdata),
        .m_axi_rresp  (rresp),
        .m_axi_rvalid (rvalid),
        .m_axi_rready (rready)
    );

    localparam logic [127:0] Key  = 128'h00010203_04050607_08090A0B_0C0D0E0F;
    localparam logic [127:0] Iv   = 128'hF0F1F2F3_F4F5F6F7_F8F9FAFB_FCFDFEFF;
    localparam logic [127:0] Din  = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    localparam logic [127:0] Dout = 128'h69C4E0D8_6A7B0430_D8CDB780_70B4C55A;

    logic [31:0] exp_wa [15] = '{32'h10, 32'h14, 32'h18, 32'h1C, 32'h20, 32'h24, 32'h28,
                                 32'h2C, 32'h30, 32'h34, 32'h38, 32'h3C, 32'h08, 32'h00,
                                 32'h00};
    logic [31:0] exp_wd [15] = '{32'h00010203, 32'h04050607, 32'h08090A0B, 32'h0C0D0E0F,
                                 32'hF0F1F2F3, 32'hF4F5F6F7, 32'hF8F9FAFB, 32'hFCFDFEFF,
                                 32'h00112233, 32'h44556677, 32'h8899AABB, 32'hCCDDEEFF,
                                 32'h00000008, 32'h00000001, 32'h00000000};
    logic [31:0] dout_w [4] = '{32'h69C4E0D8, 32'h6A7B0430, 32'hD8CDB780, 32'h70B4C55A};

    int checks = 0;
    int errors = 0;

    // Slave model configuration (driven only by the stimulus process)
    int          aw_delay = 0;
    int          w_delay  = 0;
    int          done_on  = 1;
    logic [31:0] err_addr = 32'hFFFF_FFFF;
    logic        slv_clr  = 1'b0;

    // Slave model state and logs
    logic        aw_got, w_got, aw_pend, w_pend, ar_pend;
    logic [31:0] aw_addr_l, w_data_l, aw_prev, w_prev, ar_prev;
    int          aw_cnt, w_cnt;
    logic [31:0] wr_addr [64];
    logic [31:0] wr_data [64];
    logic [31:0] rd_addr [64];
    int          wr_n, rd_n, st_reads, dout_reads, b_hs_n, viol, accepts;
    logic        aw_hs, w_hs, ar_hs;

    assign awready = !aw_got && !bvalid && (aw_cnt >= aw_delay);
    assign wready  = !w_got && !bvalid && (w_cnt >= w_delay);
    assign arready = !rvalid;
    assign aw_hs   = awvalid && awready;
    assign w_hs    = wvalid && wready;
    assign ar_hs   = arvalid && arready;

    always @(posedge clk) begin
        if (reset || slv_clr) begin
            aw_got <= 1'b0; w_got <= 1'b0; aw_cnt <= 0; w_cnt <= 0;
            bvalid <= 1'b0; bresp <= 2'b00; rvalid <= 1'b0; rresp <= 2'b00; rdata <= '0;
            aw_pend <= 1'b0; w_pend <= 1'b0; ar_pend <= 1'b0;
            aw_prev <= '0; w_prev <= '0; ar_prev <= '0; aw_addr_l <= '0; w_data_l <= '0;
            wr_n <= 0; rd_n <= 0; st_reads <= 0; dout_reads <= 0; b_hs_n <= 0;
            viol <= 0; accepts <= 0;
        end else begin
            if (cmd_valid && cmd_ready) accepts <= accepts + 1;
            if (awvalid && !aw_hs && !aw_got) aw_cnt <= aw_cnt + 1;
            if (wvalid && !w_hs && !w_got) w_cnt <= w_cnt + 1;
            if (aw_hs) begin aw_got <= 1'b1; aw_addr_l <= awaddr; end
            if (w_hs) begin w_got <= 1'b1; w_data_l <= wdata; end
            if (!bvalid && (aw_got || aw_hs) && (w_got || w_hs)) begin
                bvalid <= 1'b1;
                bresp  <= ((aw_hs ? awaddr : aw_addr_l) == err_addr) ? 2'b10 : 2'b00;
                if (wr_n < 64) begin
                    wr_addr[wr_n] <= aw_hs ? awaddr : aw_addr_l;
                    wr_data[wr_n] <= w_hs ? wdata : w_data_l;
                end
                wr_n <= wr_n + 1;
            end
            if (bvalid && bready) begin
                bvalid <= 1'b0; aw_got <= 1'b0; w_got <= 1'b0; aw_cnt <= 0; w_cnt <= 0;
                b_hs_n <= b_hs_n + 1;
            end
            if (ar_hs) begin
                rvalid <= 1'b1;
                rresp  <= 2'b00;
                if (rd_n < 64) rd_addr[rd_n] <= araddr;
                rd_n <= rd_n + 1;
                if (araddr == 32'h0C) begin
                    st_reads <= st_reads + 1;
                    rdata    <= {31'd0, (done_on != 0) && (st_reads + 1 >= done_on)};
                end else if (araddr[31:4] == 28'h4) begin
                    dout_reads <= dout_reads + 1;
                    rdata      <= dout_w[araddr[3:2]];
                end else begin
                    rdata <= 32'hDEAD_BEEF;
                end
            end
            if (rvalid && rready) rvalid <= 1'b0;
            // Protocol watch: valid held while pending, stable payload, no repeat, no overlap
            aw_pend <= awvalid && !aw_hs;
            w_pend  <= wvalid && !w_hs;
            ar_pend <= arvalid && !ar_hs;
            aw_prev <= awaddr;
            w_prev  <= wdata;
            ar_prev <= araddr;
            if ((aw_pend && (!awvalid || awaddr != aw_prev)) ||
                (w_pend && (!wvalid || wdata != w_prev)) ||
                (ar_pend && (!arvalid || araddr != ar_prev)) ||
                (awvalid && aw_got) || (wvalid && w_got) ||
                ((awvalid || wvalid || bready) && (arvalid || rready)))
                viol <= viol + 1;
        end
    end

    logic [127:0] got_data;
    logic         got_err;
    int           got_cycles;

    task automatic clear_logs();
        slv_clr = 1'b1;
        @(posedge clk); #1;
        slv_clr = 1'b0;
    endtask

    task automatic run_job(input logic [2:0] mode, input logic enc);
        cmd_key = Key; cmd_iv = Iv; cmd_data = Din; cmd_mode = mode; cmd_enc_dec = enc;
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid  = 1'b0;
        got_cycles = 0;
        while (!res_valid && got_cycles < 2000) begin
            @(posedge clk); #1;
            got_cycles++;
        end
        if (!res_valid) begin
            checks++; errors++;
            $display("FAIL job_timeout: res_valid still %0b after %0d cycles, required 1",
                     res_valid, got_cycles);
        end
        got_data  = res_data;
        got_err   = res_err;
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++; $display("FAIL reset_cmd_ready: got %0b want 1", cmd_ready);
        end
        checks++;
        if ({awvalid, wvalid, bready, arvalid, rready, res_valid} !== 6'b0) begin
            errors++;
            $display("FAIL reset_valids: got %b want 000000",
                     {awvalid, wvalid, bready, arvalid, rready, res_valid});
        end
        checks++;
        if ({awaddr, wdata, araddr} !== 96'd0) begin
            errors++; $display("FAIL reset_addr_data: got %h %h %h want 0", awaddr, wdata, araddr);
        end
        checks++;
        if (res_data !== 128'd0 || res_err !== 1'b0) begin
            errors++; $display("FAIL reset_result: got %h err %0b want 0", res_data, res_err);
        end
    endtask

    task automatic test_zero_wait();
        aw_delay = 0; w_delay = 0; done_on = 1;
        clear_logs();
        run_job(3'd0, 1'b1);
        checks++;
        if (wr_n !== 15) begin
            errors++; $display("FAIL zw_write_count: got %0d want 15", wr_n);
        end
        for (int i = 0; i < 15; i++) begin
            checks++;
            if (wr_addr[i] !== exp_wa[i] || wr_data[i] !== exp_wd[i]) begin
                errors++;
                $display("FAIL zw_write_%0d: got %h=%h want %h=%h", i, wr_addr[i], wr_data[i],
                         exp_wa[i], exp_wd[i]);
            end
        end
        checks++;
        if (rd_n !== 5 || rd_addr[0] !== 32'h0C || rd_addr[1] !== 32'h40 ||
            rd_addr[4] !== 32'h4C) begin
            errors++;
            $display("FAIL zw_reads: got n=%0d %h %h %h want 5 0c 40 4c", rd_n, rd_addr[0],
                     rd_addr[1], rd_addr[4]);
        end
        checks++;
        if (got_data !== Dout || got_err !== 1'b0) begin
            errors++; $display("FAIL zw_result: got %h err %0b want %h err 0", got_data, got_err, Dout);
        end
        checks++;
        if (got_cycles !== 60) begin
            errors++; $display("FAIL zw_latency: got %0d cycles want 60", got_cycles);
        end
        checks++;
        if (viol !== 0) begin
            errors++; $display("FAIL zw_protocol: got %0d violations want 0", viol);
        end
    endtask

    task automatic test_split_ready();
        for (int j = 0; j < 2; j++) begin
            aw_delay = (j == 0) ? 0 : 3;
            w_delay  = (j == 0) ? 3 : 0;
            done_on  = 1;
            clear_logs();
            run_job(3'd2, 1'b0);
            checks++;
            if (wr_n !== 15 || b_hs_n !== 15) begin
                errors++; $display("FAIL split%0d_counts: got w=%0d b=%0d want 15 15", j, wr_n, b_hs_n);
            end
            for (int i = 0; i < 12; i++) begin
                checks++;
                if (wr_addr[i] !== exp_wa[i] || wr_data[i] !== exp_wd[i]) begin
                    errors++;
                    $display("FAIL split%0d_write_%0d: got %h=%h want %h=%h", j, i, wr_addr[i],
                             wr_data[i], exp_wa[i], exp_wd[i]);
                end
            end
            checks++;
            if (wr_data[12] !== 32'h2) begin
                errors++; $display("FAIL split%0d_mode: got %h want 00000002", j, wr_data[12]);
            end
            checks++;
            if (viol !== 0 || got_data !== Dout || got_err !== 1'b0) begin
                errors++;
                $display("FAIL split%0d_result: got viol=%0d %h err %0b want 0 %h err 0", j, viol,
                         got_data, got_err, Dout);
            end
        end
        aw_delay = 0; w_delay = 0;
    endtask

    task automatic test_poll5();
        done_on = 5;
        clear_logs();
        run_job(3'd0, 1'b1);
        checks++;
        if (st_reads !== 5 || dout_reads !== 4 || rd_n !== 9) begin
            errors++;
            $display("FAIL poll5_reads: got st=%0d dout=%0d n=%0d want 5 4 9", st_reads,
                     dout_reads, rd_n);
        end
        checks++;
        if (rd_addr[4] !== 32'h0C || rd_addr[5] !== 32'h40) begin
            errors++; $display("FAIL poll5_order: got %h %h want 0c 40", rd_addr[4], rd_addr[5]);
        end
        checks++;
        if (got_data !== Dout || got_err !== 1'b0 || wr_n !== 15) begin
            errors++;
            $display("FAIL poll5_result: got %h err %0b w=%0d want %h 0 15", got_data, got_err,
                     wr_n, Dout);
        end
    endtask

    task automatic test_timeout();
        done_on = 0;
        clear_logs();
        run_job(3'd0, 1'b1);
        checks++;
        if (st_reads !== 8 || dout_reads !== 0) begin
            errors++; $display("FAIL to_reads: got st=%0d dout=%0d want 8 0", st_reads, dout_reads);
        end
        checks++;
        if (wr_n !== 15 || wr_addr[14] !== 32'h0 || wr_data[14] !== 32'h0 ||
            wr_data[13] !== 32'h1) begin
            errors++;
            $display("FAIL to_ctrl_clear: got n=%0d %h=%h want 15 0=0", wr_n, wr_addr[14],
                     wr_data[14]);
        end
        checks++;
        if (got_err !== 1'b1 || got_data !== 128'd0) begin
            errors++; $display("FAIL to_result: got %h err %0b want 0 err 1", got_data, got_err);
        end
        done_on = 1;
    endtask

    task automatic test_bresp_err();
        err_addr = 32'h24;
        clear_logs();
        run_job(3'd0, 1'b1);
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (wr_n !== 6 || rd_n !== 0 || wr_addr[5] !== 32'h24) begin
            errors++;
            $display("FAIL berr_traffic: got w=%0d r=%0d last=%h want 6 0 24", wr_n, rd_n,
                     wr_addr[5]);
        end
        checks++;
        if (got_err !== 1'b1 || got_data !== 128'd0) begin
            errors++; $display("FAIL berr_result: got %h err %0b want 0 err 1", got_data, got_err);
        end
        err_addr = 32'hFFFF_FFFF;
    endtask

    task automatic test_backpressure();
        logic [127:0] snap;
        int           n;
        clear_logs();
        cmd_key = Key; cmd_iv = Iv; cmd_data = Din; cmd_mode = 3'd1; cmd_enc_dec = 1'b1;
        cmd_valid = 1'b1;
        n = 0;
        @(posedge clk); #1;
        while (!res_valid && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        snap = res_data;
        checks++;
        if (res_valid !== 1'b1 || snap !== Dout) begin
            errors++; $display("FAIL bp_first: got v=%0b %h want 1 %h", res_valid, snap, Dout);
        end
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            checks++;
            if (res_valid !== 1'b1 || res_data !== snap || res_err !== 1'b0 || cmd_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold_%0d: got v=%0b %h err %0b rdy %0b want 1 %h 0 0", i,
                         res_valid, res_data, res_err, cmd_ready, snap);
            end
        end
        cmd_valid = 1'b0;
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        checks++;
        if (res_valid !== 1'b0 || cmd_ready !== 1'b1 || accepts !== 1 || wr_n !== 15) begin
            errors++;
            $display("FAIL bp_release: got v=%0b rdy=%0b acc=%0d w=%0d want 0 1 1 15", res_valid,
                     cmd_ready, accepts, wr_n);
        end
    endtask

    task automatic test_reset_mid();
        aw_delay = 5;
        clear_logs();
        cmd_key = Key; cmd_iv = Iv; cmd_data = Din; cmd_mode = 3'd0; cmd_enc_dec = 1'b1;
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        checks++;
        if (awvalid !== 1'b1 || wvalid !== 1'b1 || wstrb !== 4'hF || awaddr !== 32'h10) begin
            errors++;
            $display("FAIL rm_in_wrreq: got aw=%0b w=%0b strb=%h addr=%h want 1 1 f 10", awvalid,
                     wvalid, wstrb, awaddr);
        end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        checks++;
        if ({awvalid, wvalid, bready, arvalid, rready, res_valid} !== 6'b0 || cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL rm_after_reset: got %b rdy %0b want 000000 rdy 1",
                     {awvalid, wvalid, bready, arvalid, rready, res_valid}, cmd_ready);
        end
        aw_delay = 0;
        clear_logs();
        run_job(3'd0, 1'b1);
        checks++;
        if (got_data !== Dout || got_err !== 1'b0 || wr_n !== 15) begin
            errors++;
            $display("FAIL rm_recover: got %h err %0b w=%0d want %h 0 15", got_data, got_err,
                     wr_n, Dout);
        end
    endtask

    initial begin
        cmd_valid = 1'b0; res_ready = 1'b0; reset = 1'b1;
        cmd_key = '0; cmd_iv = '0; cmd_data = '0; cmd_mode = '0; cmd_enc_dec = 1'b0;
        test_reset();
        test_zero_wait();
        test_split_ready();
        test_poll5();
        test_timeout();
        test_bresp_err();
        test_backpressure();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
